// File: rtl/bsg_quantum_rr_arbiter.sv
// Round-robin time-slice arbiter. Each grant lasts limit+1 cycles, and the limit is captured at the arbitration edge.
// Optional feature: define BSG_QUANTUM_RR_ARBITER_EARLY_RELEASE_EN to end a slice when its owner drops its request.
module bsg_quantum_rr_arbiter #(
  parameter int els_p   = 4,
  parameter int width_p = 16,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [els_p-1:0]     reqs_i,
  input  logic [width_p-1:0]   limit_i,
  output logic [els_p-1:0]     grants_o,
  output logic [lg_els_lp-1:0] owner_id_o,
  output logic [width_p-1:0]   count_o,
  output logic                 slice_last_o
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [lg_els_lp-1:0] owner_q, owner_d;
  logic [lg_els_lp-1:0] ptr_q, ptr_d;
  logic [width_p-1:0]   limit_q, limit_d;
  logic [width_p-1:0]   count_q, count_d;

  logic                 release_w;
  logic                 end_w;
  logic                 arb_w;
  logic                 found_w;
  logic [lg_els_lp-1:0] winner_w;

  // Returns {found, index}: first set request at or after ptr, wrapping modulo els_p.
  function automatic logic [lg_els_lp:0] rr_scan(input logic [lg_els_lp-1:0] ptr,
                                                 input logic [els_p-1:0]     reqs);
    logic                 found;
    logic [lg_els_lp-1:0] win;
    int                   idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < els_p; i++) begin
      idx = (int'(ptr) + i) % els_p;
      if (!found && reqs[lg_els_lp'(idx)]) begin
        found = 1'b1;
        win   = lg_els_lp'(idx);
      end
    end
    return {found, win};
  endfunction

`ifdef BSG_QUANTUM_RR_ARBITER_EARLY_RELEASE_EN
  assign release_w = ~reqs_i[owner_q];
`else
  assign release_w = 1'b0;
`endif

  assign {found_w, winner_w} = rr_scan(ptr_q, reqs_i);
  assign end_w = (state_q == GRANT) && ((count_q == limit_q) || release_w);
  assign arb_w = (state_q == IDLE) || end_w;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      limit_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      limit_q <= limit_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    limit_d = limit_q;
    count_d = count_q;
    if (arb_w) begin
      count_d = '0;
      if (found_w) begin
        state_d = GRANT;
        owner_d = winner_w;
        ptr_d   = (int'(winner_w) == els_p - 1) ? '0 : winner_w + lg_els_lp'(1);
        limit_d = limit_i;
      end else begin
        state_d = IDLE;
        owner_d = '0;
      end
    end else if (state_q == GRANT) begin
      count_d = count_q + width_p'(1);
    end
  end

  always_comb begin
    grants_o = '0;
    if (state_q == GRANT) grants_o[owner_q] = 1'b1;
    slice_last_o = end_w;
  end

  assign owner_id_o = owner_q;
  assign count_o    = count_q;

endmodule
